monitor_event_scheduler: RTL

//  Sequences timestamped input events into the RTLola monitor (topEntity) input port.

---
 rtl/monitor_sched_pkg.sv | 19 +
 rtl/sched_event_fifo.sv | 58 +++++
 rtl/monitor_event_scheduler.sv | 106 ++++++++++
 3 files changed

// File: rtl/monitor_sched_pkg.sv
// Shared types for the monitor event scheduler: FSM states, default widths, event record.
package monitor_sched_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_DELTA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DEF_DELTA_W-1:0] delta;
    logic [DEF_DATA_W-1:0]  data;
  } sched_event_t;

endpackage

// File: rtl/sched_event_fifo.sv
// Small synchronous FIFO holding pending (delta, data) events; flush empties it and
// wins over a same-cycle push or pop.
module sched_event_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/monitor_event_scheduler.sv
// Pops timestamped events, idles <delta> cycles, then strobes the value into the
// monitor input, keeping at least MIN_GAP+1 cycles between strobes.
module monitor_event_scheduler
  import monitor_sched_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DELTA_W = DEF_DELTA_W,
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [DELTA_W-1:0] ev_delta,
  input  logic [DATA_W-1:0]  ev_data,
  output logic [DATA_W-1:0]  input_0,
  output logic               new_input_0,
  output logic               busy,
  output logic [15:0]        issued_cnt,
  output logic [1:0]         dbg_state
);

  // Host handshake: an event transfers on a rising edge where ev_valid && ev_ready
  // and flush is low; ev_ready depends only on FIFO occupancy, never on ev_valid.

  sched_state_e        state_q;
  logic [DELTA_W-1:0]  dly_cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         issued_cnt_q;

  logic [DATA_W+DELTA_W-1:0] head;
  logic [DELTA_W-1:0]        head_delta;
  logic [DATA_W-1:0]         head_data;
  logic                      fifo_full, fifo_empty, fifo_pop;

  assign fifo_pop   = en && !flush && (state_q == ST_IDLE) && !fifo_empty;
  assign head_delta = head[DATA_W +: DELTA_W];
  assign head_data  = head[DATA_W-1:0];

  sched_event_fifo #(
    .W     (DATA_W + DELTA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (flush),
    .push_i  (ev_valid),
    .wdata_i ({ev_delta, ev_data}),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // dly_cnt doubles as the GAP counter since the two phases never overlap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dly_cnt_q    <= '0;
      data_q       <= '0;
      issued_cnt_q <= '0;
    end else if (flush && (state_q == ST_WAIT || state_q == ST_GAP)) begin
      state_q <= ST_IDLE;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            dly_cnt_q <= head_delta;
            data_q    <= head_data;
            state_q   <= (head_delta == '0) ? ST_ISSUE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dly_cnt_q == DELTA_W'(1)) state_q <= ST_ISSUE;
          else dly_cnt_q <= dly_cnt_q - DELTA_W'(1);
        end
        ST_ISSUE: begin
          issued_cnt_q <= issued_cnt_q + 16'd1;
          if (MIN_GAP > 1) begin
            state_q   <= ST_GAP;
            dly_cnt_q <= DELTA_W'(MIN_GAP - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (dly_cnt_q == DELTA_W'(1)) state_q <= ST_IDLE;
          else dly_cnt_q <= dly_cnt_q - DELTA_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobe is gated by en so a stalled ISSUE holds without firing.
  assign new_input_0 = (state_q == ST_ISSUE) && en;
  assign input_0     = new_input_0 ? data_q : '0;
  assign ev_ready    = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign issued_cnt  = issued_cnt_q;
  assign dbg_state   = state_q;

endmodule
